// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO controller family.
// Read-mode selectors used by the FWFT parameter of sync_fifo_ctrl.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/fifomem.sv
// Dual-port FIFO storage: synchronous write port, combinational read port.
// Reused unchanged from the dual-clock FIFO; here wclk is driven by the single system clock.
module fifomem #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             wclk,
   input  logic             wclken,
   input  logic             wfull,
   input  logic [ASIZE-1:0] waddr,
   input  logic [ASIZE-1:0] raddr,
   input  logic [DSIZE-1:0] wdata,
   output logic [DSIZE-1:0] rdata
);

   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];

   assign rdata = mem[raddr];

   // NOTE: the array has no reset; pointers alone define which words are valid,
   // so clearing storage would only add a reset net to every bit.
   always_ff @(posedge wclk) begin
      if (wclken && !wfull) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with standard or first-word-fall-through read mode,
// fill level, almost-full/almost-empty flags, sticky error flags and synchronous flush.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DSIZE      = 8,
   parameter int ASIZE      = 4,
   parameter int FWFT       = FIFO_MODE_STD,
   parameter int AFULL_THR  = (1 << ASIZE) - 2,
   parameter int AEMPTY_THR = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] wdata,
   input  logic             winc,
   input  logic             rinc,
   input  logic             flush,
   input  logic             clr_err,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic             underflow
);

   localparam bit            IS_FWFT = (FWFT == FIFO_MODE_FWFT);
   localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic             out_valid_q, out_valid_d;
   logic [DSIZE-1:0] rdata_q, rdata_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic [ASIZE:0]   mem_count;
   logic             mem_empty;
   logic [DSIZE-1:0] mem_rdata;
   logic             wr_en;
   logic             pop;
   logic             fetch;

   // Pointer MSBs differ only once the writer has lapped the reader.
   assign mem_count = wptr_q - rptr_q;
   assign mem_empty = (wptr_q == rptr_q);
   assign wfull     = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                      (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
   assign rempty    = IS_FWFT ? !out_valid_q : mem_empty;
   assign level     = mem_count + {{ASIZE{1'b0}}, out_valid_q};

   assign walmost_full  = (int'(level) >= AFULL_THR);
   assign ralmost_empty = (int'(level) <= AEMPTY_THR);

   assign rdata     = rdata_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   fifomem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_fifomem (
      .wclk   (clk),
      .wclken (wr_en),
      .wfull  (wfull),
      .waddr  (wptr_q[ASIZE-1:0]),
      .raddr  (rptr_q[ASIZE-1:0]),
      .wdata  (wdata),
      .rdata  (mem_rdata)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      out_valid_d = out_valid_q;
      rdata_d     = rdata_q;

      wr_en = winc && !wfull && !flush;
      pop   = rinc && !rempty && !flush;

      // In FWFT mode the memory head is pulled forward whenever the output register frees up.
      if (IS_FWFT) begin
         fetch = (!out_valid_q || pop) && !mem_empty && !flush;
      end else begin
         fetch = pop;
      end

      if (flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         out_valid_d = 1'b0;
      end else begin
         if (wr_en) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (fetch) begin
            rptr_d  = rptr_q + PTR_ONE;
            rdata_d = mem_rdata;
         end
         if (IS_FWFT) begin
            if (fetch) begin
               out_valid_d = 1'b1;
            end else if (pop) begin
               out_valid_d = 1'b0;
            end
         end
      end

      // A fresh error event outranks a concurrent clear; flushed requests are not errors.
      overflow_d  = (overflow_q && !clr_err) || (winc && wfull && !flush);
      underflow_d = (underflow_q && !clr_err) || (rinc && rempty && !flush);
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // the same pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         out_valid_q <= 1'b0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         out_valid_q <= out_valid_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: a standard-mode and an FWFT-mode instance share one stimulus
// stream and are compared every cycle against queue-based reference models.
module tb_sync_fifo_ctrl;

   localparam int DSIZE      = 8;
   localparam int ASIZE      = 2;
   localparam int DEPTH      = 1 << ASIZE;
   localparam int AFULL_THR  = 3;
   localparam int AEMPTY_THR = 1;

   logic             clk;
   logic             rst_n;
   logic [DSIZE-1:0] wdata;
   logic             winc;
   logic             rinc;
   logic             flush;
   logic             clr_err;

   logic [DSIZE-1:0] s_rdata, f_rdata;
   logic             s_wfull, f_wfull;
   logic             s_rempty, f_rempty;
   logic             s_afull, f_afull;
   logic             s_aempty, f_aempty;
   logic [ASIZE:0]   s_level, f_level;
   logic             s_ovf, f_ovf;
   logic             s_unf, f_unf;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [DSIZE-1:0] q_s[$];
   logic [DSIZE-1:0] m_rd_s;
   logic             m_ovf_s, m_unf_s;
   logic [DSIZE-1:0] q_f[$];
   logic             m_ov_f;
   logic [DSIZE-1:0] m_rd_f;
   logic             m_ovf_f, m_unf_f;

   sync_fifo_ctrl #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0),
      .AFULL_THR(AFULL_THR), .AEMPTY_THR(AEMPTY_THR)
   ) u_std (
      .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
      .flush(flush), .clr_err(clr_err), .rdata(s_rdata), .wfull(s_wfull),
      .rempty(s_rempty), .walmost_full(s_afull), .ralmost_empty(s_aempty),
      .level(s_level), .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo_ctrl #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1),
      .AFULL_THR(AFULL_THR), .AEMPTY_THR(AEMPTY_THR)
   ) u_fwft (
      .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
      .flush(flush), .clr_err(clr_err), .rdata(f_rdata), .wfull(f_wfull),
      .rempty(f_rempty), .walmost_full(f_afull), .ralmost_empty(f_aempty),
      .level(f_level), .overflow(f_ovf), .underflow(f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_s.delete();
      q_f.delete();
      m_rd_s  = '0;
      m_rd_f  = '0;
      m_ov_f  = 1'b0;
      m_ovf_s = 1'b0;
      m_unf_s = 1'b0;
      m_ovf_f = 1'b0;
      m_unf_f = 1'b0;
   endtask

   // One clock edge of both models, from the inputs presented before the edge.
   task automatic model_step();
      bit s_full, s_empty, f_full, f_pop;
      s_full  = (q_s.size() == DEPTH);
      s_empty = (q_s.size() == 0);
      f_full  = (q_f.size() == DEPTH);
      if (clr_err) begin
         m_ovf_s = 1'b0; m_unf_s = 1'b0;
         m_ovf_f = 1'b0; m_unf_f = 1'b0;
      end
      if (flush) begin
         q_s.delete();
         q_f.delete();
         m_ov_f = 1'b0;
      end else begin
         if (winc && s_full)  m_ovf_s = 1'b1;
         if (rinc && s_empty) m_unf_s = 1'b1;
         if (rinc && !s_empty) m_rd_s = q_s.pop_front();
         if (winc && !s_full) q_s.push_back(wdata);

         if (winc && f_full)  m_ovf_f = 1'b1;
         if (rinc && !m_ov_f) m_unf_f = 1'b1;
         f_pop = rinc && m_ov_f;
         if ((!m_ov_f || f_pop) && q_f.size() != 0) begin
            m_rd_f = q_f.pop_front();
            m_ov_f = 1'b1;
         end else if (f_pop) begin
            m_ov_f = 1'b0;
         end
         if (winc && !f_full) q_f.push_back(wdata);
      end
   endtask

   task automatic compare_all();
      int ls, lf;
      ls = q_s.size();
      lf = q_f.size() + int'(m_ov_f);
      check("std.rdata",  32'(s_rdata),  32'(m_rd_s));
      check("std.wfull",  32'(s_wfull),  32'(ls == DEPTH));
      check("std.rempty", 32'(s_rempty), 32'(ls == 0));
      check("std.afull",  32'(s_afull),  32'(ls >= AFULL_THR));
      check("std.aempty", 32'(s_aempty), 32'(ls <= AEMPTY_THR));
      check("std.level",  32'(s_level),  32'(ls));
      check("std.ovf",    32'(s_ovf),    32'(m_ovf_s));
      check("std.unf",    32'(s_unf),    32'(m_unf_s));
      check("fwft.wfull",  32'(f_wfull),  32'(q_f.size() == DEPTH));
      check("fwft.rempty", 32'(f_rempty), 32'(!m_ov_f));
      check("fwft.afull",  32'(f_afull),  32'(lf >= AFULL_THR));
      check("fwft.aempty", 32'(f_aempty), 32'(lf <= AEMPTY_THR));
      check("fwft.level",  32'(f_level),  32'(lf));
      check("fwft.ovf",    32'(f_ovf),    32'(m_ovf_f));
      check("fwft.unf",    32'(f_unf),    32'(m_unf_f));
      if (m_ov_f) check("fwft.rdata", 32'(f_rdata), 32'(m_rd_f));
   endtask

   task automatic drive(input logic w, input logic r, input logic f, input logic c,
                        input logic [DSIZE-1:0] d);
      winc = w; rinc = r; flush = f; clr_err = c; wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic rand_drive();
      drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5),
            8'($urandom));
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 8'h00);
      model_reset();
      @(negedge clk);
      compare_all();
      check("rst.std_level", 32'(s_level), 32'd0);
      check("rst.std_rempty", 32'(s_rempty), 32'd1);
      rst_n = 1'b1;

      // Fill the standard FIFO, then overflow it.
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 8'(8'h11 * (i + 1)));
         step();
         if (i == 2) check("s1.afull_at3", 32'(s_afull), 32'd1);
      end
      check("s1.wfull", 32'(s_wfull), 32'd1);
      check("s1.level", 32'(s_level), 32'd4);
      drive(1, 0, 0, 0, 8'h55);
      step();
      check("s1.overflow", 32'(s_ovf), 32'd1);
      check("s1.level_hold", 32'(s_level), 32'd4);

      // Drain it in order, then underflow.
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, 8'h00);
         step();
         check("s2.rdata", 32'(s_rdata), 32'(8'h11 * (i + 1)));
      end
      check("s2.rempty", 32'(s_rempty), 32'd1);
      drive(0, 1, 0, 0, 8'h00);
      step();
      check("s2.underflow", 32'(s_unf), 32'd1);
      check("s2.rdata_hold", 32'(s_rdata), 32'h44);

      drive(0, 0, 1, 1, 8'h00);
      step();

      // FWFT: first word appears two edges after the write.
      drive(1, 0, 0, 0, 8'hA5);
      step();
      check("s3.rempty_edge1", 32'(f_rempty), 32'd1);
      drive(0, 0, 0, 0, 8'h00);
      step();
      check("s3.rdata", 32'(f_rdata), 32'hA5);
      check("s3.rempty", 32'(f_rempty), 32'd0);
      check("s3.level1", 32'(f_level), 32'd1);
      check("s3.aempty", 32'(f_aempty), 32'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 8'(8'hB0 + i));
         step();
      end
      check("s3.level5", 32'(f_level), 32'd5);
      check("s3.wfull", 32'(f_wfull), 32'd1);

      // Steady state: concurrent push/pop at level 2.
      drive(0, 0, 1, 1, 8'h00);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 8'(i + 1));
         step();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 0, 8'(8'h10 + i));
         step();
         check("s4.std_level", 32'(s_level), 32'd2);
         check("s4.fwft_level", 32'(f_level), 32'd2);
         check("s4.no_err", 32'({s_ovf, s_unf, f_ovf, f_unf}), 32'd0);
      end

      // Flush outranks concurrent requests; a set event outranks clr_err.
      drive(0, 0, 1, 0, 8'h00);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 8'(8'h61 + i));
         step();
      end
      drive(1, 1, 1, 0, 8'h99);
      step();
      check("s5.std_level", 32'(s_level), 32'd0);
      check("s5.fwft_level", 32'(f_level), 32'd0);
      check("s5.rempty", 32'({s_rempty, f_rempty}), 32'd3);
      check("s5.no_err", 32'({s_ovf, s_unf, f_ovf, f_unf}), 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 8'(8'h70 + i));
         step();
      end
      drive(1, 0, 0, 1, 8'hEE);
      step();
      check("s5.std_ovf_wins", 32'(s_ovf), 32'd1);
      check("s5.fwft_ovf_wins", 32'(f_ovf), 32'd1);
      drive(0, 0, 0, 1, 8'h00);
      step();
      check("s5.ovf_cleared", 32'({s_ovf, f_ovf}), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rand_drive();
         step();
      end

      // Asynchronous reset between clock edges, mid-burst.
      drive(1, 1, 0, 0, 8'h3C);
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      check("s6.std_rdata", 32'(s_rdata), 32'd0);
      check("s6.rempty", 32'({s_rempty, f_rempty}), 32'd3);
      check("s6.level", 32'({s_level, f_level}), 32'd0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rand_drive();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
